// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - event codes, event record and debounce FSM states for key_event_gen
package key_pkg;

  localparam logic [1:0] EV_PRESS   = 2'b01;
  localparam logic [1:0] EV_RELEASE = 2'b10;
  localparam logic [1:0] EV_LONG    = 2'b11;

  typedef struct packed {
    logic [1:0] ev_type;
    logic [2:0] key;
  } key_event_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_WAIT,
    ST_PRESSED,
    ST_RELEASE_WAIT
  } key_state_t;

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - one button: 2-flop synchronizer, debounce FSM, hold counter
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES     = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int unsigned MAXC = (LONG_CYCLES > DEBOUNCE_CYCLES) ? LONG_CYCLES : DEBOUNCE_CYCLES;
  localparam int unsigned CW   = (MAXC > 2) ? $clog2(MAXC) : 1;
  // The entry edge into a wait state is the first accepted sample, so the
  // counter only has to reach DEBOUNCE_CYCLES-2 before the level flips.
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 2);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] LONG_PRE  = CW'(LONG_CYCLES - 2);

  logic          sync1_q, sync2_q;
  key_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, hold_q, hold_d;
  logic          level_q, level_d;
  logic          press_q, press_d, release_q, release_d, long_q, long_d;

  // Bring the raw pin into the clock domain; idle level is released (1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
    end
  end

  // Next state: filter the synced level and time how long the key is held.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!sync2_q) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (sync2_q) begin
          state_d = ST_IDLE;
        end else if (cnt_q == DB_LAST) begin
          state_d = ST_PRESSED;
          level_d = 1'b1;
          press_d = 1'b1;
          hold_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PRESSED: begin
        if (sync2_q) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = '0;
        end else if (hold_q != LONG_LAST) begin
          // Saturating at LONG_LAST makes long-press fire once per press,
          // even across a rejected release bounce.
          hold_d = hold_q + 1'b1;
          long_d = (hold_q == LONG_PRE);
        end
      end
      ST_RELEASE_WAIT: begin
        if (!sync2_q) begin
          state_d = ST_PRESSED;
        end else if (cnt_q == DB_LAST) begin
          state_d   = ST_IDLE;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hold_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;

endmodule

// File: rtl/key_event_gen.sv
// rtl/key_event_gen.sv - debounced key events with a pending-flag queue and valid/ready output slot
module key_event_gen
  import key_pkg::*;
#(
  parameter int          N_KEYS          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES     = 50_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] long_pulse,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [1:0]        ev_type,
  output logic [2:0]        ev_key,
  output logic              ev_overflow
);

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_db (
      .clk      (clk),
      .rst_n    (rst_n),
      .key_n_i  (key_n[g]),
      .level_o  (key_level[g]),
      .press_o  (press_pulse[g]),
      .release_o(release_pulse[g]),
      .long_o   (long_pulse[g])
    );
  end

  logic [N_KEYS-1:0] pend_press_q, pend_press_d;
  logic [N_KEYS-1:0] pend_long_q, pend_long_d;
  logic [N_KEYS-1:0] pend_rel_q, pend_rel_d;
  logic [N_KEYS-1:0] sel_press, sel_long, sel_rel;
  logic [N_KEYS-1:0] clr_press, clr_long, clr_rel;
  logic              sel_found, load;
  key_event_t        sel_ev, slot_q;
  logic              valid_q, ovf_q, ovf_d;

  // Arbiter: lowest key wins; within a key press beats long beats release.
  always_comb begin
    sel_found = 1'b0;
    sel_ev    = '0;
    sel_press = '0;
    sel_long  = '0;
    sel_rel   = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (!sel_found) begin
        if (pend_press_q[i]) begin
          sel_found    = 1'b1;
          sel_press[i] = 1'b1;
          sel_ev       = '{ev_type: EV_PRESS, key: 3'(i)};
        end else if (pend_long_q[i]) begin
          sel_found   = 1'b1;
          sel_long[i] = 1'b1;
          sel_ev      = '{ev_type: EV_LONG, key: 3'(i)};
        end else if (pend_rel_q[i]) begin
          sel_found  = 1'b1;
          sel_rel[i] = 1'b1;
          sel_ev     = '{ev_type: EV_RELEASE, key: 3'(i)};
        end
      end
    end
  end

  // Flag update: clear what the slot takes, then set from new pulses so a
  // pulse racing its own load is kept rather than flagged as lost.
  always_comb begin
    load         = !valid_q && sel_found;
    clr_press    = sel_press & {N_KEYS{load}};
    clr_long     = sel_long & {N_KEYS{load}};
    clr_rel      = sel_rel & {N_KEYS{load}};
    pend_press_d = (pend_press_q & ~clr_press) | press_pulse;
    pend_long_d  = (pend_long_q & ~clr_long) | long_pulse;
    pend_rel_d   = (pend_rel_q & ~clr_rel) | release_pulse;
    ovf_d        = ovf_q
                 | (|(press_pulse & pend_press_q & ~clr_press))
                 | (|(long_pulse & pend_long_q & ~clr_long))
                 | (|(release_pulse & pend_rel_q & ~clr_rel));
  end

  // Pending flags and the sticky lost-event indicator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_press_q <= '0;
      pend_long_q  <= '0;
      pend_rel_q   <= '0;
      ovf_q        <= 1'b0;
    end else begin
      pend_press_q <= pend_press_d;
      pend_long_q  <= pend_long_d;
      pend_rel_q   <= pend_rel_d;
      ovf_q        <= ovf_d;
    end
  end

  // Output slot: load only when empty, so a reload lands the cycle after a handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      slot_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      slot_q  <= sel_ev;
    end else if (valid_q && ev_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign ev_valid    = valid_q;
  assign ev_type     = slot_q.ev_type;
  assign ev_key      = slot_q.key;
  assign ev_overflow = ovf_q;

endmodule
